fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on Reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, instruction word inserted on flush/reset.
REQ-003 Clk  input  1  rising-edge clock for all state.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Stall  input  1  hazard hold: freeze PC and IF/ID register.
REQ-006 Flush  input  1  squash: load NOP_WORD into IF/ID on next edge.
REQ-007 BranchTaken  input  1  redirect PC to BranchTarget.
REQ-008 BranchTarget  input  32  branch destination byte address.
REQ-009 Jump  input  1  redirect PC to JumpTarget.
REQ-010 JumpTarget  input  32  jump destination byte address.
REQ-011 IMemAddress  output  32  byte address presented to instruction memory (equals PC).
REQ-012 IMemInstruction  input  32  word returned combinationally by instruction memory for IMemAddress.
REQ-013 IF_ID_Instruction  output  32  registered fetched instruction.
REQ-014 IF_ID_PCPlus4  output  32  registered PC+4 of that instruction.
REQ-015 IF_ID_Valid  output  1  high when IF/ID holds a real (non-squashed) instruction.

Function
REQ-016 IMemAddress SHALL be driven combinationally from the PC register; bits [1:0] SHALL be forwarded unmodified.
REQ-017 Next-PC priority SHALL be: Reset > BranchTaken > Jump > Stall(hold) > PC+4.
- BranchTaken beats Jump: branch resolves in an older pipeline stage.
- Redirects SHALL override Stall.
REQ-018 PC+4 SHALL be 32-bit unsigned; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
REQ-019 Fetch latency SHALL be one cycle: IMemInstruction sampled at edge N appears on IF_ID_Instruction after edge N.
REQ-020 IF/ID update priority SHALL be: Reset > Flush > Stall(hold) > load {IMemInstruction, PC+4, Valid=1}.
REQ-021 Flush SHALL load IF_ID_Instruction=NOP_WORD, IF_ID_PCPlus4=0, IF_ID_Valid=0, even when Stall=1.
REQ-022 A redirect without Flush SHALL still load the currently fetched word into IF/ID (delay-slot behaviour is the controller's choice).
REQ-023 Stall with no redirect SHALL keep PC and all IF/ID outputs bit-identical.
REQ-024 Unit SHALL contain two logical states, RUN and HOLD (HOLD = Stall asserted with no redirect); transitions are evaluated every cycle, no multi-cycle states.

Reset
REQ-025 On Reset at a rising edge: PC=RESET_PC, IF_ID_Instruction=NOP_WORD, IF_ID_PCPlus4=0, IF_ID_Valid=0.
REQ-026 Reset mid-stall or mid-redirect SHALL discard pending Stall/Flush/redirect inputs for that edge.
REQ-027 First valid IF/ID entry SHALL appear one edge after Reset deasserts, containing memory[RESET_PC>>2].

Configuration
REQ-028 Macro FETCH_PERF_COUNT_EN SHALL, when defined, add output FetchCount (32) counting edges that load a valid IF/ID entry and output StallCount (32) counting edges in HOLD; both reset to 0 and wrap at 2^32.
REQ-029 Without FETCH_PERF_COUNT_EN the counters and ports SHALL be absent; all other behaviour identical.

Structure
REQ-030 Shared package fetch_pkg SHALL hold RESET_PC default, NOP_WORD, PC increment constant (4) and the RUN/HOLD state encoding.
REQ-031 One sub-module, pc_register, SHALL hold the PC and next-PC mux; IF/ID register and counters live in fetch_unit.

Verification
REQ-032 Reset 2 cycles, release, memory[i]=i*3 -> IF_ID_Instruction sequence 0,3,6; IF_ID_PCPlus4 4,8,12; Valid=1.
REQ-033 Stall=1 for 3 cycles at PC=0x10 -> IMemAddress stays 0x10, IF/ID unchanged, StallCount +3 (macro on).
REQ-034 BranchTaken=1, BranchTarget=0x40, Jump=1, JumpTarget=0x80, Flush=1 same cycle -> next IMemAddress 0x40, IF_ID_Valid=0, IF_ID_Instruction=NOP_WORD.
REQ-035 Jump=1 to 0x20 with Stall=1 -> PC becomes 0x20 next edge; IF/ID held.
REQ-036 PC forced to 0xFFFF_FFFC via JumpTarget, no stall -> next IMemAddress 0x0000_0000.
REQ-037 Reset asserted while Stall=1 and BranchTaken=1 -> PC=RESET_PC, IF_ID_Valid=0, counters 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and PC arithmetic for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCREMENT     = 32'd4;

  typedef enum logic {
    StRun  = 1'b0,
    StHold = 1'b1
  } fetch_state_e;

  // Unsigned 32-bit add; 0xFFFF_FFFC wraps to 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + PC_INCREMENT;
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter with next-PC select: reset > branch > jump > hold > sequential.
module pc_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic [31:0] pc_next_seq
);

  assign pc_next_seq = pc_plus4(pc);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (branch_taken) begin
      pc <= branch_target;
    end else if (jump) begin
      pc <= jump_target;
    end else if (!hold) begin
      pc <= pc_next_seq;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IF/ID pipeline register and, with FETCH_PERF_COUNT_EN
// defined, fetch/stall performance counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] IMemAddress,
  input  logic [31:0] IMemInstruction,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
`endif
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  pc_next_seq;

  // HOLD only when stalled without a redirect; redirects always move the PC.
  always_comb begin
    state = StRun;
    if (Stall && !BranchTaken && !Jump) begin
      state = StHold;
    end
  end

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk           (Clk),
    .reset         (Reset),
    .hold          (state == StHold),
    .branch_taken  (BranchTaken),
    .branch_target (BranchTarget),
    .jump          (Jump),
    .jump_target   (JumpTarget),
    .pc            (pc),
    .pc_next_seq   (pc_next_seq)
  );

  assign IMemAddress = pc;

  // IF/ID holds on any Stall, even when the PC is being redirected.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      IF_ID_Instruction <= NOP_WORD;
      IF_ID_PCPlus4     <= 32'h0;
      IF_ID_Valid       <= 1'b0;
    end else if (Flush) begin
      IF_ID_Instruction <= NOP_WORD;
      IF_ID_PCPlus4     <= 32'h0;
      IF_ID_Valid       <= 1'b0;
    end else if (!Stall) begin
      IF_ID_Instruction <= IMemInstruction;
      IF_ID_PCPlus4     <= pc_next_seq;
      IF_ID_Valid       <= 1'b1;
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      FetchCount <= 32'h0;
      StallCount <= 32'h0;
    end else begin
      if (!Flush && !Stall) begin
        FetchCount <= FetchCount + 32'd1;
      end
      if (state == StHold) begin
        StallCount <= StallCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit; memory model returns (address >> 2) * 3.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'hDEAD_BEEF;

  logic        Clk;
  logic        Reset;
  logic        Stall;
  logic        Flush;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic [31:0] IMemAddress;
  logic [31:0] IMemInstruction;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] FetchCount;
  logic [31:0] StallCount;
`endif

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (NOP)
  ) dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .Stall             (Stall),
    .Flush             (Flush),
    .BranchTaken       (BranchTaken),
    .BranchTarget      (BranchTarget),
    .Jump              (Jump),
    .JumpTarget        (JumpTarget),
    .IMemAddress       (IMemAddress),
    .IMemInstruction   (IMemInstruction),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_PCPlus4     (IF_ID_PCPlus4),
    .IF_ID_Valid       (IF_ID_Valid)
`ifdef FETCH_PERF_COUNT_EN
    ,
    .FetchCount        (FetchCount),
    .StallCount        (StallCount)
`endif
  );

  assign IMemInstruction = (IMemAddress >> 2) * 32'd3;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic [31:0] e_fcnt;
    logic [31:0] e_scnt;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic stall, input logic flush, input logic br,
                       input logic [31:0] bt, input logic jmp, input logic [31:0] jt);
    Reset        = rst;
    Stall        = stall;
    Flush        = flush;
    BranchTaken  = br;
    BranchTarget = bt;
    Jump         = jmp;
    JumpTarget   = jt;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic add(input logic rst, input logic stall, input logic flush, input logic br,
                     input logic [31:0] bt, input logic jmp, input logic [31:0] jt,
                     input logic [31:0] a, input logic [31:0] i, input logic [31:0] p,
                     input logic v, input logic [31:0] fc, input logic [31:0] sc);
    vec_t t;
    t = '{rst, stall, flush, br, bt, jmp, jt, a, i, p, v, fc, sc};
    vecs.push_back(t);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    //  rst stl fl br bt            jmp jt             addr          instr         pc4           v  fc  sc
    add(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        NOP,          32'h0,        0, 0, 0);
    add(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        NOP,          32'h0,        0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        32'd0,        32'h4,        1, 1, 0);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h8,        32'd3,        32'h8,        1, 2, 0);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'hC,        32'd6,        32'hC,        1, 3, 0);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h10,       32'd9,        32'h10,       1, 4, 0);
    add(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h10,       32'd9,        32'h10,       1, 4, 1);
    add(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h10,       32'd9,        32'h10,       1, 4, 2);
    add(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h10,       32'd9,        32'h10,       1, 4, 3);
    add(0, 0, 1, 1, 32'h40,       1, 32'h80,       32'h40,       NOP,          32'h0,        0, 4, 3);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h44,       32'd48,       32'h44,       1, 5, 3);
    add(0, 1, 0, 0, 32'h0,        1, 32'h20,       32'h20,       32'd48,       32'h44,       1, 5, 3);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h24,       32'd24,       32'h24,       1, 6, 3);
    add(0, 0, 0, 1, 32'h100,      0, 32'h0,        32'h100,      32'd27,       32'h28,       1, 7, 3);
    add(0, 0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd192,    32'h104,      1, 8, 3);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'hBFFF_FFFD, 32'h0,       1, 9, 3);
    add(0, 0, 1, 0, 32'h0,        0, 32'h0,        32'h4,        NOP,          32'h0,        0, 9, 3);
    add(0, 1, 1, 0, 32'h0,        0, 32'h0,        32'h4,        NOP,          32'h0,        0, 9, 4);
    add(1, 1, 0, 1, 32'h30,       0, 32'h0,        32'h0,        NOP,          32'h0,        0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        32'd0,        32'h4,        1, 1, 0);
    add(0, 1, 0, 1, 32'h50,       0, 32'h0,        32'h50,       32'd0,        32'h4,        1, 1, 0);
    add(0, 0, 0, 0, 32'h0,        1, 32'h13,       32'h13,       32'd60,       32'h54,       1, 2, 0);
    add(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h17,       32'd12,       32'h17,       1, 3, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].rst, vecs[k].stall, vecs[k].flush, vecs[k].br, vecs[k].bt, vecs[k].jmp,
            vecs[k].jt);
      step();
      check("addr", k, IMemAddress, vecs[k].e_addr);
      check("instr", k, IF_ID_Instruction, vecs[k].e_instr);
      check("pc4", k, IF_ID_PCPlus4, vecs[k].e_pc4);
      check("valid", k, {31'b0, IF_ID_Valid}, {31'b0, vecs[k].e_valid});
`ifdef FETCH_PERF_COUNT_EN
      check("fetch_count", k, FetchCount, vecs[k].e_fcnt);
      check("stall_count", k, StallCount, vecs[k].e_scnt);
`endif
    end

    // Long hold at odd address 0x17, then release.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("hold_addr", 100 + c, IMemAddress, 32'h17);
      check("hold_instr", 100 + c, IF_ID_Instruction, 32'd12);
      check("hold_pc4", 100 + c, IF_ID_PCPlus4, 32'h17);
`ifdef FETCH_PERF_COUNT_EN
      check("hold_stall_count", 100 + c, StallCount, 32'(c + 1));
`endif
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check("release_addr", 200, IMemAddress, 32'h1B);
    check("release_instr", 200, IF_ID_Instruction, 32'd15);
    check("release_pc4", 200, IF_ID_PCPlus4, 32'h1B);
    check("release_valid", 200, {31'b0, IF_ID_Valid}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
